// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer sharing one count/compare unit.
// Confirmed level changes are queued as round-robin arbitrated events.
module debounce_scheduler #(
   parameter int NUM_CHANNELS   = 4,
   parameter int DEBOUNCE_LIMIT = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_CHANNELS-1:0]         i_bouncy,
   output logic [NUM_CHANNELS-1:0]         o_debounced,
   output logic                            o_event_valid,
   output logic [$clog2(NUM_CHANNELS)-1:0] o_event_chan,
   output logic                            o_event_level,
   input  logic                            i_event_ready,
   output logic                            o_overrun
);

   localparam int CW = $clog2(NUM_CHANNELS);
   localparam int NW = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] LAST = CW'(NUM_CHANNELS - 1);
   localparam logic [NW-1:0] CMAX = NW'(DEBOUNCE_LIMIT - 1);

   logic [NUM_CHANNELS-1:0] meta_q, sync_q;
   logic [NUM_CHANNELS-1:0] deb_q, deb_d;
   logic [NUM_CHANNELS-1:0] pend_q, pend_d;
   logic [NUM_CHANNELS-1:0] lvl_q, lvl_d;
   logic [NW-1:0]           cnt_q [NUM_CHANNELS];
   logic [NW-1:0]           cnt_d;
   logic [CW-1:0]           slot_q;
   logic [CW-1:0]           last_q;
   logic                    ev_valid_q;
   logic [CW-1:0]           ev_chan_q;
   logic                    ev_lvl_q;
   logic                    ovr_q;

   logic          svc_raw, svc_cur, svc_set;
   logic [NW-1:0] svc_cnt;
   logic          found, load, take, ovr_hit;
   logic [CW-1:0] grant, idx;

   always_comb begin
      svc_raw = sync_q[slot_q];
      svc_cur = deb_q[slot_q];
      svc_cnt = cnt_q[slot_q];
      svc_set = 1'b0;
      cnt_d   = '0;
      if (svc_raw != svc_cur) begin
         if (svc_cnt == CMAX) begin
            svc_set = 1'b1;
         end else begin
            cnt_d = svc_cnt + 1'b1;
         end
      end
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
         idx = CW'((int'(last_q) + i) % NUM_CHANNELS);
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   assign load    = !ev_valid_q || i_event_ready;
   assign take    = load && found;
   assign ovr_hit = svc_set && pend_q[slot_q]
                    && !(take && (grant == slot_q));

   // A fresh set beats a same-cycle clear of the same bit.
   always_comb begin
      pend_d = pend_q;
      lvl_d  = lvl_q;
      deb_d  = deb_q;
      if (take) begin
         pend_d[grant] = 1'b0;
      end
      if (svc_set) begin
         pend_d[slot_q] = 1'b1;
         lvl_d[slot_q]  = svc_raw;
         deb_d[slot_q]  = svc_raw;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q     <= '0;
         sync_q     <= '0;
         deb_q      <= '0;
         pend_q     <= '0;
         lvl_q      <= '0;
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            cnt_q[k] <= '0;
         end
         slot_q     <= '0;
         last_q     <= LAST;
         ev_valid_q <= 1'b0;
         ev_chan_q  <= '0;
         ev_lvl_q   <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         meta_q        <= i_bouncy;
         sync_q        <= meta_q;
         slot_q        <= (slot_q == LAST) ? '0 : slot_q + 1'b1;
         cnt_q[slot_q] <= cnt_d;
         deb_q         <= deb_d;
         pend_q        <= pend_d;
         lvl_q         <= lvl_d;
         if (load) begin
            ev_valid_q <= found;
            if (found) begin
               ev_chan_q <= grant;
               ev_lvl_q  <= lvl_q[grant];
               last_q    <= grant;
            end
         end
         if (ovr_hit) begin
            ovr_q <= 1'b1;
         end
      end
   end

   assign o_debounced   = deb_q;
   assign o_event_valid = ev_valid_q;
   assign o_event_chan  = ev_chan_q;
   assign o_event_level = ev_lvl_q;
   assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler at N=4, L=4.
// Table vectors for single presses plus hand sequences for corner cases.
module tb_debounce_scheduler;

   logic       clk;
   logic       rst_n;
   logic [3:0] bouncy;
   logic [3:0] deb;
   logic       ev_valid;
   logic [1:0] ev_chan;
   logic       ev_lvl;
   logic       ready;
   logic       ovr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [2:0] ev_q [$];

   debounce_scheduler #(
      .NUM_CHANNELS  (4),
      .DEBOUNCE_LIMIT(4)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_bouncy     (bouncy),
      .o_debounced  (deb),
      .o_event_valid(ev_valid),
      .o_event_chan (ev_chan),
      .o_event_level(ev_lvl),
      .i_event_ready(ready),
      .o_overrun    (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   ch;
      logic lvl;
      int   d;
      int   lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic step();
      if (ev_valid === 1'b1 && ready === 1'b1) begin
         ev_q.push_back({ev_chan, ev_lvl});
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // First service of ch that sees a new input lands d slots later.
   task automatic align(input int ch, input int d);
      while (((cyc + 2 + d) % 4) != ch) step();
   endtask

   task automatic wait_deb(input int ch, input logic lvl, output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (deb[ch] === lvl) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      vec_t vt [6];
      logic [3:0] exp_deb;
      int lat;
      int bad;

      vt[0] = '{ch: 2, lvl: 1'b1, d: 0, lat: 15};
      vt[1] = '{ch: 2, lvl: 1'b0, d: 3, lat: 18};
      vt[2] = '{ch: 3, lvl: 1'b1, d: 1, lat: 16};
      vt[3] = '{ch: 3, lvl: 1'b0, d: 2, lat: 17};
      vt[4] = '{ch: 0, lvl: 1'b1, d: 0, lat: 15};
      vt[5] = '{ch: 0, lvl: 1'b0, d: 1, lat: 16};

      rst_n  = 1'b0;
      bouncy = '0;
      ready  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_deb", 32'(deb), 0);
      chk("rst_valid", 32'(ev_valid), 0);
      chk("rst_chan", 32'(ev_chan), 0);
      chk("rst_level", 32'(ev_lvl), 0);
      chk("rst_ovr", 32'(ovr), 0);
      rst_n = 1'b1;
      cyc   = 0;

      exp_deb = '0;
      ready   = 1'b1;
      for (int v = 0; v < 6; v++) begin
         align(vt[v].ch, vt[v].d);
         bouncy[vt[v].ch] = vt[v].lvl;
         exp_deb[vt[v].ch] = vt[v].lvl;
         wait_deb(vt[v].ch, vt[v].lvl, lat);
         chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vt[v].lat));
         chk($sformatf("v%0d_deb", v), 32'(deb), 32'(exp_deb));
         step();
         chk($sformatf("v%0d_valid", v), 32'(ev_valid), 1);
         chk($sformatf("v%0d_chan", v), 32'(ev_chan), 32'(vt[v].ch));
         chk($sformatf("v%0d_level", v), 32'(ev_lvl), 32'(vt[v].lvl));
         step();
         chk($sformatf("v%0d_one", v), 32'(ev_valid), 0);
      end
      steps(5);

      ev_q.delete();
      bouncy[0] = 1'b1;
      steps(4);
      bouncy[0] = 1'b0;
      steps(4);
      bouncy[0] = 1'b1;
      wait_deb(0, 1'b1, lat);
      chk("bounce_lat_ok", 32'(lat >= 15 && lat <= 18), 1);
      steps(25);
      chk("bounce_count", 32'(ev_q.size()), 1);
      if (ev_q.size() > 0) chk("bounce_ev", 32'(ev_q[0]), 32'(3'b001));
      bouncy[0] = 1'b0;
      steps(30);

      ev_q.delete();
      bouncy[1] = 1'b1;
      steps(6);
      bouncy[1] = 1'b0;
      steps(30);
      chk("glitch_deb", 32'(deb), 0);
      chk("glitch_noev", 32'(ev_q.size()), 0);
      chk("glitch_ovr", 32'(ovr), 0);

      ready = 1'b0;
      align(0, 0);
      bouncy = 4'b1011;
      steps(20);
      chk("bp_deb", 32'(deb), 32'(4'b1011));
      chk("bp_valid", 32'(ev_valid), 1);
      chk("bp_chan", 32'(ev_chan), 0);
      chk("bp_level", 32'(ev_lvl), 1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!(ev_valid === 1'b1 && ev_chan === 2'd0 && ev_lvl === 1'b1))
            bad++;
      end
      chk("bp_stable", 32'(bad), 0);
      ev_q.delete();
      ready = 1'b1;
      step();
      chk("bp_next1", 32'({ev_valid, ev_chan}), 32'({1'b1, 2'd1}));
      step();
      chk("bp_next3", 32'({ev_valid, ev_chan}), 32'({1'b1, 2'd3}));
      step();
      chk("bp_drain", 32'(ev_valid), 0);
      chk("bp_order", 32'({ev_q.size(), ev_q[0], ev_q[1], ev_q[2]}),
          32'({32'd3, 3'b001, 3'b011, 3'b111}));
      bouncy = '0;
      steps(30);

      ready = 1'b0;
      bouncy[1] = 1'b1;
      steps(30);
      bouncy[1] = 1'b0;
      steps(30);
      chk("ovr_none_yet", 32'(ovr), 0);
      bouncy[1] = 1'b1;
      steps(30);
      chk("ovr_set", 32'(ovr), 1);
      bouncy[1] = 1'b0;
      steps(30);
      chk("ovr_held", 32'({ev_valid, ev_chan, ev_lvl}),
          32'({1'b1, 2'd1, 1'b1}));
      ev_q.delete();
      ready = 1'b1;
      step();
      chk("ovr_second", 32'({ev_valid, ev_chan, ev_lvl}),
          32'({1'b1, 2'd1, 1'b0}));
      step();
      chk("ovr_no_third", 32'(ev_valid), 0);
      steps(5);
      chk("ovr_count", 32'(ev_q.size()), 2);
      chk("ovr_sticky", 32'(ovr), 1);

      bouncy = 4'b1001;
      steps(30);
      chk("pre_rst_deb", 32'(deb), 32'(4'b1001));
      align(2, 0);
      bouncy[2] = 1'b1;
      steps(7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_deb", 32'(deb), 0);
      chk("arst_ovr", 32'(ovr), 0);
      chk("arst_ev", 32'({ev_valid, ev_chan, ev_lvl}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      steps(14);
      chk("rst_full_lat_lo", 32'(deb[2]), 0);
      step();
      chk("rst_full_lat_hi", 32'(deb[2]), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
